// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed multiply/divide for the execute stage.
// Ports: clock, reset_n (async, active low); ctrl_MULT/ctrl_DIV start pulses;
//   data_operandA/B operands; data_result, data_exception, data_resultRDY
//   (one-cycle strobe) and busy (start+1 through the strobe cycle).
// Optional build macro MULTDIV_BOOTH4_EN: radix-4 Booth multiply (16 iterations
//   instead of 32). Results are identical in both builds; divide is unchanged.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_ITERS = WIDTH / 2;
`else
  localparam int MUL_ITERS = WIDTH;
`endif
  localparam int DIV_ITERS = WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  // multiply datapath
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   pp;
  logic [WIDTH:0]       mplier_q, mplier_d;
  // divide datapath (operates on magnitudes)
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvsr_q;
  logic                 neg_q, dvz_q, ovf_q;
  logic [WIDTH:0]       shifted;
  logic                 fits;
  logic [WIDTH-1:0]     quo_final;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 start;

  assign start = ctrl_MULT | ctrl_DIV;

  always_comb begin
    pp = '0;
`ifdef MULTDIV_BOOTH4_EN
    // Booth group {b[2i+1], b[2i], b[2i-1]}; bit -1 is the appended zero.
    unique case (mplier_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
    mcand_d  = mcand_q << 2;
    mplier_d = {2'b00, mplier_q[WIDTH:2]};
`else
    // Bit 31 of a two's-complement multiplier carries negative weight.
    if (mplier_q[0]) begin
      pp = (cnt_q == CW'(WIDTH - 1)) ? -mcand_q : mcand_q;
    end
    mcand_d  = mcand_q << 1;
    mplier_d = {1'b0, mplier_q[WIDTH:1]};
`endif
    acc_d = acc_q + pp;

    // Restoring step: remainder is always below the divisor, so the trial
    // subtraction result fits in WIDTH bits whenever it is kept.
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvsr_q});
    rem_d   = fits ? (shifted[WIDTH-1:0] - dvsr_q) : shifted[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], fits};

    quo_final = neg_q ? -quo_q : quo_q;
    a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      acc_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvsr_q         <= '0;
      neg_q          <= 1'b0;
      dvz_q          <= 1'b0;
      ovf_q          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        // Accepted in any state: in MUL/DIV this aborts the running operation.
        state_q  <= ctrl_MULT ? MUL : DIV;
        cnt_q    <= '0;
        busy     <= 1'b1;
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
`ifdef MULTDIV_BOOTH4_EN
        mplier_q <= {data_operandB, 1'b0};
`else
        mplier_q <= {1'b0, data_operandB};
`endif
        rem_q    <= '0;
        quo_q    <= a_mag;
        dvsr_q   <= b_mag;
        neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dvz_q    <= (data_operandB == '0);
        ovf_q    <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
      end else begin
        unique case (state_q)
          MUL: begin
            if (cnt_q == CW'(MUL_ITERS)) begin
              state_q        <= DONE;
              data_result    <= acc_q[WIDTH-1:0];
              data_exception <= (acc_q[2*WIDTH-1:WIDTH] != {WIDTH{acc_q[WIDTH-1]}});
              data_resultRDY <= 1'b1;
            end else begin
              acc_q    <= acc_d;
              mcand_q  <= mcand_d;
              mplier_q <= mplier_d;
              cnt_q    <= cnt_q + CW'(1);
            end
          end
          DIV: begin
            if (cnt_q == CW'(DIV_ITERS)) begin
              state_q        <= DONE;
              data_result    <= dvz_q ? '0 : quo_final;
              data_exception <= dvz_q | ovf_q;
              data_resultRDY <= 1'b1;
            end else begin
              rem_q <= rem_d;
              quo_q <= quo_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed test-plan cases with literal expectations,
// then randomized starts (including restarts and back-to-back issue) checked
// every cycle against a timing/arithmetic model built from plain arithmetic.
module tb_multdiv_unit;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: returns {exception, result}.
  function automatic logic [32:0] model(input logic mult, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q;
    logic [31:0] r;
    logic   e;
    if (mult) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
    return {e, r};
  endfunction

  // Timing model: one pending operation, strobe lat edges after its start.
  int          edge_n = 0;
  bit          pend_v = 0;
  int          pend_edge = 0;
  int          pend_lat = 0;
  logic [31:0] pend_r = '0, hold_r = '0;
  logic        pend_e = 1'b0, hold_e = 1'b0;
  bit          chk_en = 0;

  always @(posedge clock) begin
    edge_n++;
    if (reset_n) begin
      if (pend_v && edge_n > pend_edge + pend_lat) begin
        pend_v = 0;
        hold_r = pend_r;
        hold_e = pend_e;
      end
      if (ctrl_MULT || ctrl_DIV) begin
        {pend_e, pend_r} = model(ctrl_MULT, data_operandA, data_operandB);
        pend_v    = 1;
        pend_edge = edge_n;
        pend_lat  = ctrl_MULT ? MUL_LAT : DIV_LAT;
      end
    end
  end

  always @(negedge reset_n) begin
    pend_v = 0;
    hold_r = '0;
    hold_e = 1'b0;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      logic exp_busy, exp_rdy;
      exp_busy = reset_n && pend_v && edge_n >= pend_edge && edge_n <= pend_edge + pend_lat;
      exp_rdy  = reset_n && pend_v && edge_n == pend_edge + pend_lat;
      chk("cyc_busy", 64'(busy), 64'(exp_busy));
      chk("cyc_rdy", 64'(data_resultRDY), 64'(exp_rdy));
      chk("cyc_result", 64'(data_result), 64'(exp_rdy ? pend_r : hold_r));
      chk("cyc_exception", 64'(data_exception), 64'(exp_rdy ? pend_e : hold_e));
    end
  end

  // Issue a start at the current negedge and wait (bounded) for the strobe.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee, input int lat, input string nm);
    int n, nb;
    bit got;
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = $urandom; data_operandB = $urandom;
    n = 1; nb = 0; got = 0;
    repeat (200) begin
      if (busy) nb++;
      if (data_resultRDY) begin
        got = 1;
        break;
      end
      @(negedge clock);
      n++;
    end
    chk({nm, "_strobe"}, 64'(got), 64'd1);
    chk({nm, "_latency"}, 64'(n), 64'(lat + 1));
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(lat + 1));
    chk({nm, "_result"}, 64'(data_result), 64'(er));
    chk({nm, "_exception"}, 64'(data_exception), 64'(ee));
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(0, 20));
      4:       v = 32'(0 - $urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    // Pin the reference model to hand-computed values.
    chk("model_mul_basic", 64'(model(1, 32'd7, 32'hFFFF_FFFD)), {31'd0, 1'b0, 32'hFFFF_FFEB});
    chk("model_mul_ovf", 64'(model(1, 32'h0001_0000, 32'h0001_0000)), {31'd0, 1'b1, 32'h0});
    chk("model_div_neg", 64'(model(0, 32'hFFFF_FFF9, 32'd2)), {31'd0, 1'b0, 32'hFFFF_FFFD});
    chk("model_div_dvz", 64'(model(0, 32'd5, 32'd0)), {31'd0, 1'b1, 32'h0});

    repeat (3) @(negedge clock);
    chk_en = 1;
    chk("reset_result", 64'(data_result), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rdy", 64'(data_resultRDY), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, MUL_LAT, "mul_basic");
    @(negedge clock);
    run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1, MUL_LAT, "mul_ovf");
    @(negedge clock);
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1, MUL_LAT, "mul_minsq");
    @(negedge clock);
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, DIV_LAT, "div_neg_a");
    @(negedge clock);
    run_op(0, 1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, DIV_LAT, "div_neg_b");
    @(negedge clock);
    run_op(0, 1, 32'd5, 32'd0, 32'h0, 1, DIV_LAT, "div_zero");
    @(negedge clock);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, DIV_LAT, "div_ovf");
    @(negedge clock);
    run_op(1, 1, 32'd100, 32'd3, 32'd300, 0, MUL_LAT, "priority");

    // Restart: divide aborted ten cycles in by a multiply.
    @(negedge clock);
    begin
      int strobes;
      strobes = 0;
      ctrl_DIV = 1; data_operandA = 32'd1000; data_operandB = 32'd3;
      @(negedge clock);
      ctrl_DIV = 0;
      repeat (9) begin
        if (data_resultRDY) strobes++;
        @(negedge clock);
      end
      chk("restart_no_early_strobe", 64'(strobes), 64'd0);
    end
    run_op(1, 0, 32'd6, 32'd7, 32'd42, 0, MUL_LAT, "restart");

    // Back-to-back: second start issued in the first strobe cycle.
    @(negedge clock);
    run_op(0, 1, 32'd1000, 32'd3, 32'd333, 0, DIV_LAT, "b2b_first");
    run_op(1, 0, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFF7, 0, MUL_LAT, "b2b_second");

    // Asynchronous reset in the middle of a divide.
    @(negedge clock);
    ctrl_DIV = 1; data_operandA = 32'd77; data_operandB = 32'd5;
    @(negedge clock);
    ctrl_DIV = 0;
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_result", 64'(data_result), 64'd0);
    chk("arst_exception", 64'(data_exception), 64'd0);
    chk("arst_rdy", 64'(data_resultRDY), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    begin
      int strobes;
      strobes = 0;
      repeat (40) begin
        @(negedge clock);
        if (data_resultRDY || busy) strobes++;
      end
      chk("arst_quiet_after_release", 64'(strobes), 64'd0);
    end

    // Randomized starts with random spacing; the compare process checks every cycle.
    for (int i = 0; i < 300; i++) begin
      int gap, sel;
      sel = $urandom_range(0, 4);
      ctrl_MULT = (sel <= 1) || (sel == 4);
      ctrl_DIV  = (sel >= 2);
      data_operandA = rnd_opnd();
      data_operandB = rnd_opnd();
      @(negedge clock);
      ctrl_MULT = 0; ctrl_DIV = 0;
      data_operandA = $urandom; data_operandB = $urandom;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : $urandom_range(MUL_LAT - 1, DIV_LAT + 4);
      repeat (gap - 1) @(negedge clock);
    end
    repeat (40) @(negedge clock);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
